seg_scan_driver: RTL

Multiplexed driver for a bank of DIGITS seven-segment digits. It takes a packed hex word with per-digit decimal-point and blank masks and captures it on a load strobe. The captured word is applied atomically at frame boundaries. The driver time-multiplexes the digits with a programmable dwell time and an anti-ghosting guard interval. It sits between datapath/debug logic and the board's shared segment bus and digit-select lines.

---
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_scan_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Bus between the datapath and seg_scan_driver: display word in, pin-level scan signals out.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic                load;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   digit_sel;
  logic                frame_tick;

  modport master (
    output value, dp_in, blank_in, load,
    input  seg, dp, digit_sel, frame_tick
  );

  modport slave (
    input  value, dp_in, blank_in, load,
    output seg, dp, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-atomic display updates and guard interval.
// Optional: define SEG_LZ_SUPPRESS_EN to darken leading-zero digits (digit 0 always shown).
module seg_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int GUARD      = 2,
  parameter int ACTIVE_LOW = 0
) (
  input logic        clk,
  input logic        rst,
  seg_scan_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic                first_reg;
  logic                boundary;
  logic [4*DIGITS-1:0] pend_value_reg, pend_value_next;
  logic [DIGITS-1:0]   pend_dp_reg, pend_dp_next;
  logic [DIGITS-1:0]   pend_blank_reg, pend_blank_next;
  logic [4*DIGITS-1:0] shad_value_reg, shad_value_next;
  logic [DIGITS-1:0]   shad_dp_reg, shad_dp_next;
  logic [DIGITS-1:0]   shad_blank_reg, shad_blank_next;
  logic [6:0]          seg_reg, seg_next;
  logic                dp_reg, dp_next;
  logic [DIGITS-1:0]   sel_reg, sel_next;
  logic                tick_reg, tick_next;
  logic [3:0]          nibble_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // The first edge after reset only settles the scan at (0,0); it neither advances nor ticks.
  always_comb begin
    cnt_next = cnt_reg;
    idx_next = idx_reg;
    boundary = first_reg;
    if (!first_reg) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        if (idx_reg == IDX_LAST) begin
          idx_next = '0;
          boundary = 1'b1;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    pend_value_next = bus.load ? bus.value    : pend_value_reg;
    pend_dp_next    = bus.load ? bus.dp_in    : pend_dp_reg;
    pend_blank_next = bus.load ? bus.blank_in : pend_blank_reg;

    // A load on the boundary edge bypasses pending straight into the new frame.
    shad_value_next = boundary ? pend_value_next : shad_value_reg;
    shad_dp_next    = boundary ? pend_dp_next    : shad_dp_reg;
    shad_blank_next = boundary ? pend_blank_next : shad_blank_reg;
  end

`ifdef SEG_LZ_SUPPRESS_EN
  logic [DIGITS-1:0] zero_from;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign zero_from[gi] = ~|shad_value_next[4*DIGITS-1:4*gi];
  end
`endif

  // Outputs are computed from next-state so the registered pins line up with (idx, cnt).
  always_comb begin
    nibble_next = shad_value_next[{idx_next, 2'b00} +: 4];
    seg_next    = hex7(nibble_next);
    dp_next     = shad_dp_next[idx_next];
`ifdef SEG_LZ_SUPPRESS_EN
    if ((idx_next != '0) && zero_from[idx_next]) begin
      seg_next = '0;
    end
`endif
    if (shad_blank_next[idx_next]) begin
      seg_next = '0;
      dp_next  = 1'b0;
    end
    sel_next  = (cnt_next < GUARD_C) ? '0 : (DIGITS'(1) << idx_next);
    tick_next = boundary && !first_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      first_reg      <= 1'b1;
      pend_value_reg <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '0;
      shad_value_reg <= '0;
      shad_dp_reg    <= '0;
      shad_blank_reg <= '0;
      seg_reg        <= {7{INV}};
      dp_reg         <= INV;
      sel_reg        <= {DIGITS{INV}};
      tick_reg       <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      first_reg      <= 1'b0;
      pend_value_reg <= pend_value_next;
      pend_dp_reg    <= pend_dp_next;
      pend_blank_reg <= pend_blank_next;
      shad_value_reg <= shad_value_next;
      shad_dp_reg    <= shad_dp_next;
      shad_blank_reg <= shad_blank_next;
      seg_reg        <= seg_next ^ {7{INV}};
      dp_reg         <= dp_next ^ INV;
      sel_reg        <= sel_next ^ {DIGITS{INV}};
      tick_reg       <= tick_next;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.digit_sel  = sel_reg;
  assign bus.frame_tick = tick_reg;

endmodule
